// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared game-state type, BCD constant and counter-width helper
package flappy_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } game_state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // Width of a down-counter that must hold cycles-1; never narrower than one bit.
    function automatic int freeze_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/score_sequencer_if.sv
// rtl/score_sequencer_if.sv - game event inputs and score/status outputs of the sequencer
interface score_sequencer_if #(
    parameter int NDIG = 3
);
    logic                  start_in;
    logic                  pass_in;
    logic                  hit_in;
    logic [4*NDIG-1:0]     score;
    logic [4*NDIG-1:0]     high;
    logic                  playing;
    logic                  game_over;
    logic                  new_high;

    // Game logic / stimulus side: drives events, observes score and status.
    modport master (
        output start_in, pass_in, hit_in,
        input  score, high, playing, game_over, new_high
    );

    // Sequencer side.
    modport slave (
        input  start_in, pass_in, hit_in,
        output score, high, playing, game_over, new_high
    );
endinterface

// File: rtl/score_sequencer_bcd_digit.sv
// rtl/score_sequencer_bcd_digit.sv - one BCD score digit with clear, increment and carry
module bcd_digit
    import flappy_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc_in,
    output logic [3:0] q,
    output logic       carry_out
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next digit value: clear wins over increment, 9 wraps to 0.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (inc_in) begin
            q_d = (q_q == BCD_NINE) ? 4'd0 : q_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign carry_out = inc_in & (q_q == BCD_NINE);

endmodule

// File: rtl/score_sequencer.sv
// rtl/score_sequencer.sv - game-flow FSM owning the BCD score and high-score registers
module score_sequencer
    import flappy_pkg::*;
#(
    parameter int NDIG          = 3,
    parameter int FREEZE_CYCLES = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    score_sequencer_if.slave   bus
);

    localparam int            FW          = freeze_w(FREEZE_CYCLES);
    localparam logic [FW-1:0] FREEZE_LOAD = FW'(FREEZE_CYCLES - 1);

    game_state_t         state_q, state_d;
    logic [FW-1:0]       cnt_q, cnt_d;
    logic                start_q, start_d;
    logic                pass_q, pass_d;
    logic [4*NDIG-1:0]   high_q, high_d;
    logic                new_high_q, new_high_d;
    logic                playing_q, playing_d;
    logic                game_over_q, game_over_d;

    logic                start_rise;
    logic                pass_rise;
    logic                score_clr;
    logic                score_inc;
    logic                saturated;
    logic [NDIG-1:0]     is_nine;
    logic [NDIG:0]       carry;
    logic [4*NDIG-1:0]   score_w;
    logic                unused_top_carry;

    assign start_rise = bus.start_in & ~start_q;
    assign pass_rise  = bus.pass_in & ~pass_q;
    assign saturated  = &is_nine;

    // Increments stop at all-nines, so the top digit's carry never leaves the chain.
    assign carry[0]         = score_inc & ~saturated;
    assign unused_top_carry = carry[NDIG];

    genvar k;
    generate
        for (k = 0; k < NDIG; k++) begin : g_dig
            bcd_digit u_dig (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (score_clr),
                .inc_in    (carry[k]),
                .q         (score_w[4*k +: 4]),
                .carry_out (carry[k+1])
            );
            assign is_nine[k] = (score_w[4*k +: 4] == BCD_NINE);
        end
    endgenerate

    // Game flow: next state, freeze countdown, score control and high-score capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        high_d      = high_q;
        new_high_d  = new_high_q;
        start_d     = bus.start_in;
        pass_d      = bus.pass_in;
        score_clr   = 1'b0;
        score_inc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    state_d   = S_PLAY;
                    score_clr = 1'b1;
                end
            end
            S_PLAY: begin
                // A collision in the same cycle as a pass forfeits that point.
                if (bus.hit_in) begin
                    state_d = S_DYING;
                    cnt_d   = FREEZE_LOAD;
                end else if (pass_rise) begin
                    score_inc = 1'b1;
                end
            end
            S_DYING: begin
                if (cnt_q == '0) begin
                    state_d = S_OVER;
                    // BCD digits are 0..9, so unsigned compare orders scores correctly.
                    if (score_w > high_q) begin
                        high_d     = score_w;
                        new_high_d = 1'b1;
                    end else begin
                        new_high_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - FW'(1);
                end
            end
            S_OVER: begin
                if (start_rise) begin
                    state_d    = S_PLAY;
                    score_clr  = 1'b1;
                    new_high_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        playing_d   = (state_d == S_PLAY);
        game_over_d = (state_d == S_DYING) || (state_d == S_OVER);
    end

    // State, counter, edge-detect and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            pass_q      <= 1'b0;
            high_q      <= '0;
            new_high_q  <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            pass_q      <= pass_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
            playing_q   <= playing_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.score     = score_w;
    assign bus.high      = high_q;
    assign bus.playing   = playing_q;
    assign bus.game_over = game_over_q;
    assign bus.new_high  = new_high_q;

endmodule

// File: tb/tb_score_sequencer.sv
// tb/tb_score_sequencer.sv - directed table and sequence bench for score_sequencer
module tb_score_sequencer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_failed;

    score_sequencer_if #(.NDIG(3)) bus ();

    score_sequencer #(.NDIG(3), .FREEZE_CYCLES(50)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        pass;
        logic        hit;
        logic [11:0] score;
        logic        playing;
        logic        game_over;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pass_pulse();
        bus.pass_in = 1'b1;
        tick();
        bus.pass_in = 1'b0;
        tick();
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;

        // Vectors start right after reset release, state IDLE, score 0.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 12'h001, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 12'h001, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 12'h002, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 12'h003, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 12'h003, 1'b1, 1'b0};

        rst_n        = 1'b0;
        bus.start_in = 1'b0;
        bus.pass_in  = 1'b0;
        bus.hit_in   = 1'b0;

        // Reset and release.
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst score", bus.score, 12'h000);
        check("rst high", bus.high, 12'h000);
        check("rst playing", bus.playing, 1'b0);
        check("rst game_over", bus.game_over, 1'b0);
        check("rst new_high", bus.new_high, 1'b0);

        // Table: start, edge-detected passes, start ignored in PLAY.
        for (int i = 0; i < 8; i++) begin
            bus.start_in = vecs[i].start;
            bus.pass_in  = vecs[i].pass;
            bus.hit_in   = vecs[i].hit;
            tick();
            check($sformatf("vec%0d score", i), bus.score, vecs[i].score);
            check($sformatf("vec%0d playing", i), bus.playing, vecs[i].playing);
            check($sformatf("vec%0d game_over", i), bus.game_over, vecs[i].game_over);
        end
        bus.start_in = 1'b0;
        bus.pass_in  = 1'b0;

        // Up to 12 points, then a long pass counts once.
        repeat (9) pass_pulse();
        check("score 12", bus.score, 12'h012);
        check("playing 12", bus.playing, 1'b1);
        bus.pass_in = 1'b1;
        repeat (5) tick();
        bus.pass_in = 1'b0;
        tick();
        check("held pass once", bus.score, 12'h013);

        // Hit and pass rise together: no point, then freeze for 50 cycles.
        bus.hit_in  = 1'b1;
        bus.pass_in = 1'b1;
        tick();
        bus.hit_in  = 1'b0;
        bus.pass_in = 1'b0;
        check("hit wins score", bus.score, 12'h013);
        check("dying playing", bus.playing, 1'b0);
        check("dying game_over", bus.game_over, 1'b1);
        for (int i = 0; i < 49; i++) begin
            bus.pass_in = i[0];
            tick();
        end
        bus.pass_in = 1'b0;
        check("dying high not yet", bus.high, 12'h000);
        check("dying score held", bus.score, 12'h013);
        tick();
        check("over high", bus.high, 12'h013);
        check("over new_high", bus.new_high, 1'b1);
        check("over game_over", bus.game_over, 1'b1);

        // Restart keeps high, clears score.
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        check("restart playing", bus.playing, 1'b1);
        check("restart score", bus.score, 12'h000);
        check("restart high", bus.high, 12'h013);
        check("restart new_high", bus.new_high, 1'b0);

        // Second, lower game.
        repeat (5) pass_pulse();
        check("game2 score", bus.score, 12'h005);
        bus.hit_in = 1'b1;
        tick();
        bus.hit_in = 1'b0;
        repeat (49) tick();
        check("game2 dying game_over", bus.game_over, 1'b1);
        tick();
        check("game2 high kept", bus.high, 12'h013);
        check("game2 new_high", bus.new_high, 1'b0);
        repeat (3) pass_pulse();
        check("over pass ignored", bus.score, 12'h005);
        check("over game_over held", bus.game_over, 1'b1);

        // Saturation run.
        bus.start_in = 1'b1;
        tick();
        bus.start_in = 1'b0;
        check("game3 score", bus.score, 12'h000);
        for (int n = 1; n <= 997; n++) begin
            pass_pulse();
            if (n == 10)  check("carry 10", bus.score, 12'h010);
            if (n == 100) check("carry 100", bus.score, 12'h100);
        end
        check("preload 997", bus.score, 12'h997);
        pass_pulse();
        check("sat 998", bus.score, 12'h998);
        pass_pulse();
        check("sat 999", bus.score, 12'h999);
        pass_pulse();
        check("sat hold 1", bus.score, 12'h999);
        pass_pulse();
        check("sat hold 2", bus.score, 12'h999);
        check("sat playing", bus.playing, 1'b1);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async score", bus.score, 12'h000);
        check("async high", bus.high, 12'h000);
        check("async playing", bus.playing, 1'b0);
        check("async game_over", bus.game_over, 1'b0);
        check("async new_high", bus.new_high, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
